// File: rtl/axis_upsize_w2x_pkg.sv
// axis_upsize_w2x_pkg: state encoding and default widths shared by the upsizer and its partner downsizer.
package axis_upsize_w2x_pkg;
  typedef enum logic {S_LO = 1'b0, S_HI = 1'b1} state_t;
  localparam int C_WIDTH_TDATA_DEF = 512;
  localparam int C_WIDTH_TKEEP_DEF = C_WIDTH_TDATA_DEF / 8;
  localparam int C_WIDTH_CNT_DEF = 32;
endpackage

// File: rtl/axis_upsize_w2x_out_reg.sv
// axis_out_reg: single valid/ready output register; a load always wins over a drain so there is no bubble.
module axis_out_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_q;
  logic [W-1:0] data_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/axis_upsize_w2x.sv
// axis_upsize_w2x: packs pairs of half-width AXI4-Stream beats into one full-width registered beat.
module axis_upsize_w2x
  import axis_upsize_w2x_pkg::*;
#(
  parameter int C_WIDTH_TDATA = C_WIDTH_TDATA_DEF,
  parameter int C_WIDTH_TKEEP = C_WIDTH_TDATA / 8,
  parameter int C_WIDTH_CNT   = C_WIDTH_CNT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_TVALID,
  output logic                       in_TREADY,
  input  logic [C_WIDTH_TDATA/2-1:0] in_TDATA,
  input  logic [C_WIDTH_TKEEP/2-1:0] in_TKEEP,
  input  logic                       in_TLAST,
  output logic                       out_TVALID,
  input  logic                       out_TREADY,
  output logic [C_WIDTH_TDATA-1:0]   out_TDATA,
  output logic [C_WIDTH_TKEEP-1:0]   out_TKEEP,
  output logic                       out_TLAST,
  output logic [C_WIDTH_CNT-1:0]     pkt_cnt
);
  localparam int H  = C_WIDTH_TDATA / 2;
  localparam int KH = C_WIDTH_TKEEP / 2;
  localparam int P  = 1 + C_WIDTH_TKEEP + C_WIDTH_TDATA;
  state_t           state_q, state_d;
  logic [H-1:0]     hold_data_q;
  logic [KH-1:0]    hold_keep_q;
  logic [C_WIDTH_CNT-1:0] pkt_cnt_q;
  logic             acc, done;
  logic [P-1:0]     pay_d, pay_q;
  assign in_TREADY = !out_TVALID | out_TREADY;
  assign acc       = in_TVALID & in_TREADY;
  always_comb begin
    state_d = acc ? ((state_q == S_LO && !in_TLAST) ? S_HI : S_LO) : state_q;
    done    = acc & ((state_q == S_HI) | in_TLAST);
    pay_d   = (state_q == S_HI) ? {in_TLAST, in_TKEEP, hold_keep_q, in_TDATA, hold_data_q}
                                : {1'b1, {KH{1'b0}}, in_TKEEP, {H{1'b0}}, in_TDATA};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LO;
      hold_data_q <= '0;
      hold_keep_q <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (acc && state_q == S_LO && !in_TLAST) begin
        hold_data_q <= in_TDATA;
        hold_keep_q <= in_TKEEP;
      end
      if (out_TVALID && out_TREADY && out_TLAST) pkt_cnt_q <= pkt_cnt_q + C_WIDTH_CNT'(1);
    end
  end
  axis_out_reg #(.W(P)) u_out (
    .clk     (clk),
    .rst     (rst),
    .load_i  (done),
    .data_i  (pay_d),
    .ready_i (out_TREADY),
    .valid_o (out_TVALID),
    .data_o  (pay_q)
  );
  assign {out_TLAST, out_TKEEP, out_TDATA} = pay_q;
  assign pkt_cnt = pkt_cnt_q;
endmodule

// File: tb/tb_axis_upsize_w2x.sv
// tb_axis_upsize_w2x: directed and random stimulus with a packed-beat scoreboard for axis_upsize_w2x.
module tb_axis_upsize_w2x;
  localparam int W = 512, K = 64, H = 256, KH = 32;
  typedef struct packed {logic l; logic [K-1:0] k; logic [W-1:0] d;} beat_t;
  logic          clk = 1'b0, rst = 1'b1;
  logic          in_TVALID = 1'b0, in_TREADY, in_TLAST = 1'b0;
  logic [H-1:0]  in_TDATA = '0;
  logic [KH-1:0] in_TKEEP = '0;
  logic          out_TVALID, out_TREADY = 1'b0, out_TLAST;
  logic [W-1:0]  out_TDATA;
  logic [K-1:0]  out_TKEEP;
  logic [31:0]   pkt_cnt;
  int            tests = 0, fails = 0, cyc = 0;
  beat_t         sb[$];
  bit            lo_pend = 0, rnd = 0;
  logic [H-1:0]  hd;
  logic [KH-1:0] hk;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  axis_upsize_w2x dut (
    .clk(clk), .rst(rst),
    .in_TVALID(in_TVALID), .in_TREADY(in_TREADY), .in_TDATA(in_TDATA), .in_TKEEP(in_TKEEP), .in_TLAST(in_TLAST),
    .out_TVALID(out_TVALID), .out_TREADY(out_TREADY), .out_TDATA(out_TDATA), .out_TKEEP(out_TKEEP), .out_TLAST(out_TLAST),
    .pkt_cnt(pkt_cnt)
  );
  always @(negedge clk) begin
    if (out_TVALID && out_TREADY) begin
      beat_t o, e;
      o = {out_TLAST, out_TKEEP, out_TDATA};
      tests++;
      assert (sb.size() > 0) else begin fails++; $error("FAIL sb_extra_beat got %0h", o); end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        assert (o === e) else begin fails++; $error("FAIL sb_beat got %0h exp %0h", o, e); end
      end
    end
  end
  task automatic check(input string tag, input logic [576:0] got, input logic [576:0] exp);
    tests++;
    assert (got === exp) else begin fails++; $error("FAIL %s got %0h exp %0h", tag, got, exp); end
  endtask
  task automatic step();
    @(posedge clk); #1;
    if (rnd) out_TREADY = ($urandom_range(0, 7) != 0);
  endtask
  task automatic model(input logic [H-1:0] d, input logic [KH-1:0] k, input logic l);
    if (lo_pend) begin
      sb.push_back({l, k, hk, d, hd});
      lo_pend = 0;
    end else if (l) sb.push_back({1'b1, {KH{1'b0}}, k, {H{1'b0}}, d});
    else begin
      hd = d; hk = k; lo_pend = 1;
    end
  endtask
  task automatic send(input logic [H-1:0] d, input logic [KH-1:0] k, input logic l);
    int n = 0;
    in_TVALID = 1'b1; in_TDATA = d; in_TKEEP = k; in_TLAST = l;
    forever begin
      @(negedge clk);
      if (in_TREADY || n >= 1000) break;
      n++;
      step();
    end
    if (!in_TREADY) begin
      fails++;
      $error("FAIL accept_timeout got no in_TREADY exp accept within 1000 cycles");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "abort");
    end
    model(d, k, l);
    step();
    in_TVALID = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    rnd = 0; out_TREADY = 1'b1;
    while ((sb.size() > 0 || out_TVALID) && n < 500) begin step(); n++; end
    check("drain_empty", sb.size(), 0);
  endtask
  function automatic logic [H-1:0] rd();
    logic [H-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  initial begin
    logic [H-1:0] p0, p1, x;
    int c0, len;
    repeat (3) step();
    rst = 1'b0;
    check("rst_valid", out_TVALID, 0);
    check("rst_data", out_TDATA, 0);
    check("rst_keep", out_TKEEP, 0);
    check("rst_last", out_TLAST, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_in_ready", in_TREADY, 1);
    out_TREADY = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(rd(), '1, i == 7);
    check("t1_no_stall", cyc - c0, 8);
    drain();
    check("t1_pkt_cnt", pkt_cnt, 1);
    send(rd(), '1, 0);
    send(rd(), '1, 0);
    send(rd(), 32'h0000_FFFF, 1);
    check("t2_keep", out_TKEEP, 64'h0000_0000_0000_FFFF);
    check("t2_last", out_TLAST, 1);
    drain();
    x = rd();
    send(x, 32'hA5A5_0F0F, 1);
    check("t3_valid_lat", out_TVALID, 1);
    check("t3_data", out_TDATA, {256'h0, x});
    check("t3_keep", out_TKEEP, {32'h0, 32'hA5A5_0F0F});
    drain();
    out_TREADY = 1'b0;
    p0 = rd(); p1 = rd();
    send(p0, '1, 0);
    send(p1, '1, 0);
    in_TVALID = 1'b1; in_TDATA = rd(); in_TKEEP = '1; in_TLAST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_in_ready_low", in_TREADY, 0);
      check("t4_stable", out_TDATA, {p1, p0});
      step();
    end
    out_TREADY = 1'b1;
    send(in_TDATA, '1, 0);
    send(rd(), '1, 1);
    check("t4_next_valid", out_TVALID, 1);
    drain();
    check("t4_pkt_cnt", pkt_cnt, 4);
    send(rd(), '1, 0);
    rst = 1'b1; step(); rst = 1'b0;
    lo_pend = 0;
    check("t5_pkt_cnt_rst", pkt_cnt, 0);
    check("t5_valid_rst", out_TVALID, 0);
    send(rd(), '1, 0);
    send(rd(), '1, 1);
    drain();
    check("t5_pkt_cnt", pkt_cnt, 1);
    rst = 1'b1; step(); rst = 1'b0;
    rnd = 1;
    for (int p = 0; p < 1000; p++) begin
      len = $urandom_range(1, 64);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 7) == 0) step();
        send(rd(), KH'($urandom), b == len - 1);
      end
    end
    drain();
    check("t6_pkt_cnt", pkt_cnt, 1000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
